// File: rtl/seq_divider_64bit_pkg.sv
// rtl/seq_divider_64bit_pkg.sv - shared ALU constants and divider state encoding
// Purpose: width, FSM state type and divide-by-zero quotient used by the divider.
package seq_divider_64bit_pkg;

    localparam int DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = {DIV_WIDTH{1'b1}};

endpackage

// File: rtl/adder_subtractor_64bit.sv
// rtl/adder_subtractor_64bit.sv - 64-bit adder/subtractor datapath
// Purpose: Out = A + B when S = 0, Out = A - B when S = 1 (modulo 2^WIDTH).
// Ports: A, B operands; S select subtract; Out result.
module adder_subtractor_64bit #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] Out
);

    assign Out = S ? (A - B) : (A + B);

endmodule

// File: rtl/seq_divider_64bit.sv
// rtl/seq_divider_64bit.sv - multi-cycle restoring signed/unsigned divider
// Purpose: one quotient bit per clock, start/done handshake.
// Ports: clk, rst (sync, active-high); start, is_signed, dividend, divisor in;
//        busy, done, quotient, remainder, div_by_zero out.
module seq_divider_64bit
    import seq_divider_64bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] dvd_bits;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] div_mag;
    logic             q_sign;
    logic             r_sign;
    logic             div0;
    logic [WIDTH:0]   r_shift;
    logic             accept;
    logic             last_iter;
    logic             div_zero_in;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dsr_abs;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_out;

    // r_shift[WIDTH] is the carry out of the shift; when set the partial
    // remainder already exceeds any WIDTH-bit divisor.
    assign r_shift     = {r, dvd_bits[WIDTH-1]};
    assign accept      = r_shift[WIDTH] | (r_shift[WIDTH-1:0] >= div_mag);
    assign last_iter   = (count == CNT_W'(WIDTH - 1));
    assign div_zero_in = (divisor == '0);
    assign dvd_abs     = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign dsr_abs     = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    // Single shared subtractor: trial subtraction in RUN, 0 - x in FIX.
    // FIX needs two negations, so it spends two cycles: count[0]=0 handles
    // the quotient, count[0]=1 the remainder.
    always_comb begin
        add_a = r_shift[WIDTH-1:0];
        add_b = div_mag;
        if (state == FIX) begin
            add_a = '0;
            add_b = count[0] ? r : q;
        end
    end

    adder_subtractor_64bit #(
        .WIDTH(WIDTH)
    ) u_addsub (
        .A  (add_a),
        .B  (add_b),
        .S  (1'b1),
        .Out(add_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Divide by zero also passes through both FIX cycles so that results are
    // registered by the same logic on both paths.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = div_zero_in ? FIX : RUN;
            RUN:  if (last_iter) state_next = FIX;
            FIX:  if (count[0]) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            dvd_bits    <= '0;
            r           <= '0;
            q           <= '0;
            div_mag     <= '0;
            q_sign      <= 1'b0;
            r_sign      <= 1'b0;
            div0        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count       <= '0;
                        div0        <= div_zero_in;
                        div_by_zero <= 1'b0;
                        dvd_bits    <= dvd_abs;
                        div_mag     <= dsr_abs;
                        // No sign fix-up on divide by zero: results are raw.
                        q_sign <= is_signed & ~div_zero_in & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_sign <= is_signed & ~div_zero_in & dividend[WIDTH-1];
                        if (div_zero_in) begin
                            q <= DIV0_QUOTIENT[WIDTH-1:0];
                            r <= dividend;
                        end else begin
                            q <= '0;
                            r <= '0;
                        end
                    end
                end
                RUN: begin
                    r        <= accept ? add_out : r_shift[WIDTH-1:0];
                    q        <= {q[WIDTH-2:0], accept};
                    dvd_bits <= dvd_bits << 1;
                    count    <= count + CNT_W'(1);
                end
                FIX: begin
                    count <= count + CNT_W'(1);
                    if (!count[0]) begin
                        if (q_sign) q <= add_out;
                    end else begin
                        if (r_sign) r <= add_out;
                        quotient    <= q;
                        remainder   <= r_sign ? add_out : r;
                        div_by_zero <= div0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
